// File: rtl/program_loader.sv
`timescale 1ns/1ps
// Boot-time loader: assembles a big-endian byte stream into 32-bit words, writes them to
// instruction memory and holds the CPU in reset until the whole program is committed.
// Define LOADER_CHECKSUM_EN to require a trailing mod-2^32 checksum word after the data.
module program_loader #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int ADDR_WIDTH     = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HEADER = 3'd0,
    S_DATA   = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK  = 3'd2,
`endif
    S_RUN    = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [31:0]         MAX_LEN = INSTR_MEM_SIZE;
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic                  r_in_ready;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_wdata;
  logic                  r_cpu_reset_n;
  logic                  r_done;
  logic                  r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]           r_sum;
`endif

  logic                  w_accept;
  logic [31:0]           w_word;
  logic                  w_word_done;
  logic [ADDR_WIDTH:0]   w_count_inc;
  logic                  w_last_word;
  logic                  w_hdr_bad;

  assign w_accept    = in_valid && in_ready;
  assign w_word      = {r_shift, in_data};
  assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
  assign w_count_inc = r_words_loaded + ONE;
  assign w_last_word = (w_count_inc == r_len);
  assign w_hdr_bad   = (w_word == 32'd0) || (w_word > MAX_LEN);

  // Reset gates in_ready directly so a byte offered during the reset cycle is never taken.
  assign in_ready     = r_in_ready && !reset;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign cpu_reset_n  = r_cpu_reset_n;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

  // NOTE: every register here uses non-blocking assignment so all decisions see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_HEADER;
      r_byte_cnt     <= 2'd0;
      r_shift        <= 24'd0;
      r_len          <= '0;
      r_words_loaded <= '0;
      r_in_ready     <= 1'b1;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= 32'd0;
      r_cpu_reset_n  <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum          <= 32'd0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      if (w_accept) begin
        r_shift    <= w_word[23:0];
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end

      case (r_state)
        S_HEADER: begin
          if (w_word_done) begin
            if (w_hdr_bad) begin
              r_state    <= S_ERROR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_len   <= w_word[ADDR_WIDTH:0];
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_word_done) begin
            r_imem_we      <= 1'b1;
            r_imem_addr    <= r_words_loaded[ADDR_WIDTH-1:0];
            r_imem_wdata   <= w_word;
            r_words_loaded <= w_count_inc;
`ifdef LOADER_CHECKSUM_EN
            r_sum          <= r_sum + w_word;
            if (w_last_word) r_state <= S_CHECK;
`else
            if (w_last_word) begin
              r_state    <= S_RUN;
              r_in_ready <= 1'b0;
            end
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_word_done) begin
            r_in_ready <= 1'b0;
            if (w_word == r_sum) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        // The CPU is released on the first RUN edge, one cycle after the last commit.
        S_RUN: begin
          r_cpu_reset_n <= 1'b1;
          r_done        <= 1'b1;
        end

        S_ERROR: begin
          r_in_ready    <= 1'b0;
          r_cpu_reset_n <= 1'b0;
          r_done        <= 1'b0;
          r_error       <= 1'b1;
        end

        default: begin
          r_state    <= S_ERROR;
          r_in_ready <= 1'b0;
          r_error    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// Self-checking bench for program_loader: table of streams plus hand-written corner cases,
// each run cycle by cycle against a stream-level reference model.
module tb_program_loader;

  localparam int          MEM   = 32;
  localparam logic [31:0] MEM_W = 32;
`ifdef LOADER_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset_n;
  logic        done;
  logic        error;
  logic [5:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] tx_words[$];
  logic [31:0] plan_words[3] = '{32'h2008_0018, 32'h2009_0005, 32'h0000_0000};

  typedef struct {
    logic [31:0] hdr;
    int          n_send;
    int          kind;      // 0 plan words, 1 index, 2 random
    int          gap;       // 0 always valid, 1 toggle, 2 random
    logic        exp_err;
    logic        exp_done;
    int          exp_words;
  } vec_t;

  program_loader #(.INSTR_MEM_SIZE(MEM), .ADDR_WIDTH(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset_n  (cpu_reset_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle reset pulse with a valid byte offered, which must be dropped.
  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    #1 check("rst_ready_during", in_ready, 0);
    @(posedge clock);
    #1;
    check("rst_addr_data", {imem_addr, imem_wdata}, 0);
    check("rst_flags", {imem_we, cpu_reset_n, done, error}, 0);
    check("rst_words", words_loaded, 0);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1 check("rst_ready_after", in_ready, 1);
  endtask

  task automatic make_stream(input logic [31:0] hdr, input int n_send, input int kind);
    logic [31:0] w;
    logic [31:0] sum;
    sum = '0;
    tx_words = {};
    tx_words.push_back(hdr);
    for (int i = 0; i < n_send; i++) begin
      case (kind)
        0:       w = plan_words[i % 3];
        1:       w = 32'(i);
        default: w = $urandom;
      endcase
      sum += w;
      tx_words.push_back(w);
    end
    if (CKS == 1 && hdr != 0 && hdr <= MEM_W) tx_words.push_back(sum);
  endtask

  // Streams tx_words and checks every cycle against the model derived from the stream itself.
  task automatic run_stream(input int gap, input logic exp_err, input logic exp_done,
                            input int exp_words, input string tag);
    logic [7:0]  bytes[$];
    logic [31:0] sum, last_addr, last_data;
    logic        hdr_bad, cks_bad, bad, vld, exp_we, exp_run;
    int          n, total, ptr, acc, cyc, post, fin, strobes;

    do_reset();
    bytes = {};
    foreach (tx_words[i]) for (int b = 3; b >= 0; b--) bytes.push_back(tx_words[i][8*b +: 8]);

    hdr_bad = (tx_words[0] == 32'd0) || (tx_words[0] > MEM_W);
    n       = hdr_bad ? 0 : int'(tx_words[0]);
    total   = hdr_bad ? 4 : 4 * (1 + n + CKS);
    sum     = '0;
    for (int k = 1; k <= n; k++) sum += tx_words[k];
    cks_bad = 1'b0;
    if (CKS == 1 && !hdr_bad) cks_bad = (tx_words[n+1] != sum);
    bad = hdr_bad || cks_bad;

    ptr = 0; acc = 0; cyc = 0; post = 0; fin = -1; strobes = 0;
    last_addr = '0; last_data = '0;
    while (!(acc == total && post >= 8)) begin
      if (cyc > 3000) begin
        checks++; errors++;
        $display("FAIL timeout %s: %0d of %0d bytes accepted, required all", tag, acc, total);
        break;
      end
      case (gap)
        0:       vld = 1'b1;
        1:       vld = (cyc % 2 == 0);
        default: vld = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = vld;
      in_data  = (vld && ptr < bytes.size()) ? bytes[ptr] : 8'($urandom);
      #1 check({tag, "_in_ready"}, in_ready, acc < total);
      @(posedge clock);
      exp_we = 1'b0;
      if (vld && acc < total) begin
        ptr++;
        acc++;
        if (acc % 4 == 0 && acc / 4 >= 2 && acc / 4 <= n + 1) begin
          exp_we    = 1'b1;
          last_addr = 32'(acc / 4 - 2);
          last_data = tx_words[acc / 4 - 1];
          strobes++;
        end
        if (acc == total) fin = cyc;
      end
      #1;
      exp_run = (fin >= 0) && (cyc > fin) && !bad;
      check({tag, "_we"}, imem_we, exp_we);
      check({tag, "_addr"}, imem_addr, last_addr);
      check({tag, "_data"}, imem_wdata, last_data);
      check({tag, "_words"}, words_loaded, strobes);
      check({tag, "_error"}, error, (fin >= 0) && bad);
      check({tag, "_done"}, {done, cpu_reset_n}, {exp_run, exp_run});
      if (acc == total) post++;
      cyc++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    check({tag, "_final_error"}, error, exp_err);
    check({tag, "_final_done"}, {done, cpu_reset_n}, {exp_done, exp_done});
    check({tag, "_final_words"}, words_loaded, exp_words);
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] part[6];

    vecs[0] = '{32'd3,          3,  0, 0, 1'b0, 1'b1, 3};
    vecs[1] = '{32'd3,          3,  0, 1, 1'b0, 1'b1, 3};
    vecs[2] = '{32'd0,          2,  2, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{32'd33,         2,  2, 2, 1'b1, 1'b0, 0};
    vecs[4] = '{32'd32,         32, 1, 0, 1'b0, 1'b1, 32};
    vecs[5] = '{32'd5,          5,  2, 2, 1'b0, 1'b1, 5};
    vecs[6] = '{32'd1,          1,  2, 1, 1'b0, 1'b1, 1};
    vecs[7] = '{32'h8000_0003,  1,  2, 0, 1'b1, 1'b0, 0};

    repeat (3) @(posedge clock);

    for (int i = 0; i < 8; i++) begin
      make_stream(vecs[i].hdr, vecs[i].n_send, vecs[i].kind);
      run_stream(vecs[i].gap, vecs[i].exp_err, vecs[i].exp_done, vecs[i].exp_words,
                 $sformatf("v%0d", i));
    end

    // Partial load interrupted by reset, then a fresh one-word program.
    part = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = part[i];
      @(posedge clock);
      #1 check("partial_we", imem_we, 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("partial_words", words_loaded, 0);
    check("partial_ready", in_ready, 1);
    tx_words = {32'd1, 32'hDEAD_BEEF};
    if (CKS == 1) tx_words.push_back(32'hDEAD_BEEF);
    run_stream(0, 1'b0, 1'b1, 1, "mid_reset");

`ifdef LOADER_CHECKSUM_EN
    tx_words = {32'd2, 32'hFFFF_FFFF, 32'd2, 32'd1};
    run_stream(1, 1'b0, 1'b1, 2, "cks_ok");
    tx_words = {32'd2, 32'hFFFF_FFFF, 32'd2, 32'd2};
    run_stream(2, 1'b1, 1'b0, 2, "cks_bad");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
